// File: rtl/arm7tdmi_pkg.sv
// Shared ARM7TDMI core package.
// Purpose : common types and constants for the decode and execute blocks.
// Contents: instr_type_t   - instruction class produced by decode
//           swap_state_t   - SWP/SWPB sequencer states
//           BYTE_LANES     - number of byte lanes on the 32-bit data bus
package arm7tdmi_pkg;

  localparam int BYTE_LANES = 4;

  typedef enum logic [3:0] {
    INSTR_DATA_PROC,
    INSTR_MULTIPLY,
    INSTR_SINGLE_SWAP,
    INSTR_BRANCH_EXCHANGE,
    INSTR_SINGLE_DATA_TRANSFER,
    INSTR_BLOCK_DATA_TRANSFER,
    INSTR_BRANCH,
    INSTR_COPROC,
    INSTR_SWI,
    INSTR_UNDEFINED
  } instr_type_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    WB
  } swap_state_t;

endpackage

// File: rtl/arm7tdmi_swap_lane.sv
// Byte-lane steering for SWP/SWPB (purely combinational).
// Ports: byte_sel  - 1 = SWPB, 0 = SWP
//        lane      - address bits [1:0]
//        rdata_raw - raw word from the memory bus
//        wsrc      - store data (Rm)
//        rdata_ext - read data as it must land in Rd
//        wdata     - write data for the memory bus
//        be        - byte enables for the memory bus
module arm7tdmi_swap_lane
  import arm7tdmi_pkg::*;
(
  input  logic                  byte_sel,
  input  logic [1:0]            lane,
  input  logic [31:0]           rdata_raw,
  input  logic [31:0]           wsrc,
  output logic [31:0]           rdata_ext,
  output logic [31:0]           wdata,
  output logic [BYTE_LANES-1:0] be
);

  logic [31:0] rot;

  // Rotate right by 8*lane; the addressed byte ends up in bits [7:0],
  // so the same rotation also serves the SWPB zero-extend path.
  always_comb begin
    case (lane)
      2'd1:    rot = {rdata_raw[7:0],  rdata_raw[31:8]};
      2'd2:    rot = {rdata_raw[15:0], rdata_raw[31:16]};
      2'd3:    rot = {rdata_raw[23:0], rdata_raw[31:24]};
      default: rot = rdata_raw;
    endcase
  end

  assign rdata_ext = byte_sel ? {24'd0, rot[7:0]} : rot;
  assign wdata     = byte_sel ? {4{wsrc[7:0]}} : wsrc;
  assign be        = byte_sel ? (4'b0001 << lane) : 4'b1111;

endmodule

// File: rtl/arm7tdmi_swap_unit.sv
// SWP/SWPB execution sequencer.
// Performs a locked read-then-write on the data port and writes the
// original memory value to Rd. All outputs are registered from the
// next-state decode, so nothing is combinational from start.
// Ports: clk, rst (sync, active-high)
//        start/swap_byte/rd_idx/rn_data/rm_data - issued swap and operands
//        mem_*   - data memory port (lock held across read and write)
//        reg_*   - register-file write port
//        busy/done/abort - pipeline stall and completion pulses
module arm7tdmi_swap_unit
  import arm7tdmi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  swap_byte,
  input  logic [3:0]            rd_idx,
  input  logic [ADDR_W-1:0]     rn_data,
  input  logic [DATA_W-1:0]     rm_data,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [BYTE_LANES-1:0] mem_be,
  output logic                  mem_lock,
  input  logic                  mem_ready,
  input  logic                  mem_abort,
  output logic                  reg_we,
  output logic [3:0]            reg_waddr,
  output logic [DATA_W-1:0]     reg_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  abort
);

  swap_state_t state_q, state_d;

  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wsrc_q, wsrc_d;
  logic                  byte_q, byte_d;
  logic [3:0]            rd_q, rd_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;

  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic                  mem_re_q, mem_re_d;
  logic                  mem_we_q, mem_we_d;
  logic [BYTE_LANES-1:0] mem_be_q, mem_be_d;
  logic                  mem_lock_q, mem_lock_d;
  logic                  reg_we_q, reg_we_d;
  logic [3:0]            reg_waddr_q, reg_waddr_d;
  logic [DATA_W-1:0]     reg_wdata_q, reg_wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  abort_q, abort_d;

  logic [31:0]           lane_rdata;
  logic [31:0]           lane_wdata;
  logic [BYTE_LANES-1:0] lane_be;
  logic                  bus_active;

  // Lane steering runs on the next-cycle captured operands; outside IDLE
  // these equal the captured registers, so the read rotation sees the
  // address of the swap in flight.
  arm7tdmi_swap_lane u_lane (
    .byte_sel  (byte_d),
    .lane      (addr_d[1:0]),
    .rdata_raw (mem_rdata),
    .wsrc      (wsrc_d),
    .rdata_ext (lane_rdata),
    .wdata     (lane_wdata),
    .be        (lane_be)
  );

  // Next-state and next-output decode. Abort is only honoured together
  // with mem_ready; an abort in either phase returns straight to IDLE
  // without touching the register file.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wsrc_d  = wsrc_q;
    byte_d  = byte_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    abort_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = rn_data;
          wsrc_d  = rm_data;
          byte_d  = swap_byte;
          rd_d    = rd_idx;
          state_d = READ;
        end
      end
      READ: begin
        if (mem_ready) begin
          if (mem_abort) begin
            abort_d = 1'b1;
            state_d = IDLE;
          end else begin
            rdata_d = lane_rdata;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (mem_ready) begin
          if (mem_abort) begin
            abort_d = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WB;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    bus_active  = (state_d == READ) || (state_d == WRITE);
    mem_re_d    = (state_d == READ);
    mem_we_d    = (state_d == WRITE);
    mem_lock_d  = bus_active;
    mem_addr_d  = '0;
    mem_be_d    = '0;
    mem_wdata_d = '0;
    if (bus_active) begin
      // Word swaps always use the aligned word; the rotation on the read
      // side is what reproduces the ARM7 unaligned-load behaviour.
      mem_addr_d = byte_d ? addr_d : {addr_d[ADDR_W-1:2], 2'b00};
      mem_be_d   = lane_be;
    end
    if (mem_we_d) begin
      mem_wdata_d = lane_wdata;
    end

    reg_we_d    = (state_d == WB);
    reg_waddr_d = reg_we_d ? rd_d : 4'd0;
    reg_wdata_d = reg_we_d ? rdata_d : '0;
    done_d      = reg_we_d;
    busy_d      = (state_d != IDLE);
  end

  // Single state/output register; reset drops the lock and cancels any
  // pending register write on the very next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wsrc_q      <= '0;
      byte_q      <= 1'b0;
      rd_q        <= 4'd0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_lock_q  <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_waddr_q <= 4'd0;
      reg_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wsrc_q      <= wsrc_d;
      byte_q      <= byte_d;
      rd_q        <= rd_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_lock_q  <= mem_lock_d;
      reg_we_q    <= reg_we_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_lock  = mem_lock_q;
  assign reg_we    = reg_we_q;
  assign reg_waddr = reg_waddr_q;
  assign reg_wdata = reg_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign abort     = abort_q;

endmodule

// File: tb/tb_arm7tdmi_swap_unit.sv
// Self-checking bench for arm7tdmi_swap_unit.
// The bench plays the memory device, issues directed and random swaps,
// and pushes the expected completion into a scoreboard that a separate
// monitor drains whenever done or abort is presented.
module tb_arm7tdmi_swap_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        swap_byte;
  logic [3:0]  rd_idx;
  logic [31:0] rn_data;
  logic [31:0] rm_data;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_re;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic        mem_lock;
  logic        mem_ready;
  logic        mem_abort;
  logic        reg_we;
  logic [3:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        busy;
  logic        done;
  logic        abort;

  typedef struct {
    bit          is_abort;
    logic [3:0]  rd;
    logic [31:0] val;
    logic [31:0] key;
    logic [31:0] final_word;
    int          cycle;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem[logic [31:0]];
  int          cyc;
  int          n_run;
  int          n_fail;

  arm7tdmi_swap_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .swap_byte (swap_byte),
    .rd_idx    (rd_idx),
    .rn_data   (rn_data),
    .rm_data   (rm_data),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_lock  (mem_lock),
    .mem_ready (mem_ready),
    .mem_abort (mem_abort),
    .reg_we    (reg_we),
    .reg_waddr (reg_waddr),
    .reg_wdata (reg_wdata),
    .busy      (busy),
    .done      (done),
    .abort     (abort)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to check completion latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case the DUT or the bench wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_get(input logic [31:0] key);
    if (!mem.exists(key)) mem[key] = $urandom;
    return mem[key];
  endfunction

  // Reference behaviour: pick bytes out of the memory word by position.
  // A word swap returns the word rotated so that the addressed byte is
  // lowest; a byte swap returns just that byte and replaces it in memory.
  function automatic void model(input bit b, input logic [31:0] addr, input logic [31:0] word,
                                input logic [31:0] rm, output logic [31:0] val,
                                output logic [31:0] new_word);
    int k;
    logic [7:0] bytes_in[4];
    k = int'(addr % 4);
    for (int i = 0; i < 4; i++) bytes_in[i] = word[8*i +: 8];
    if (b) begin
      val = {24'd0, bytes_in[k]};
      new_word = word;
      new_word[8*k +: 8] = rm[7:0];
    end else begin
      val = '0;
      for (int i = 0; i < 4; i++) val[8*i +: 8] = bytes_in[(i + k) % 4];
      new_word = rm;
    end
  endfunction

  task automatic check_bus(input bit is_write, input logic [31:0] ea, input logic [3:0] ebe,
                           input logic [31:0] ewd);
    check_output(is_write ? "w_re" : "r_re", mem_re, !is_write);
    check_output(is_write ? "w_we" : "r_we", mem_we, is_write);
    check_output(is_write ? "w_lock" : "r_lock", mem_lock, 1);
    check_output(is_write ? "w_busy" : "r_busy", busy, 1);
    check_output(is_write ? "w_reg_we" : "r_reg_we", reg_we, 0);
    check_output(is_write ? "w_addr" : "r_addr", mem_addr, ea);
    check_output(is_write ? "w_be" : "r_be", {28'd0, mem_be}, {28'd0, ebe});
    if (is_write) check_output("w_wdata", mem_wdata, ewd);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_addr"}, mem_addr, 0);
    check_output({tag, "_wdata"}, mem_wdata, 0);
    check_output({tag, "_re"}, mem_re, 0);
    check_output({tag, "_we"}, mem_we, 0);
    check_output({tag, "_be"}, {28'd0, mem_be}, 0);
    check_output({tag, "_lock"}, mem_lock, 0);
    check_output({tag, "_reg_we"}, reg_we, 0);
    check_output({tag, "_waddr"}, {28'd0, reg_waddr}, 0);
    check_output({tag, "_wdata_rf"}, reg_wdata, 0);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_done"}, done, 0);
    check_output({tag, "_abort"}, abort, 0);
  endtask

  // One swap: rw/ww are wait cycles in READ/WRITE, ab selects an abort
  // in READ (1), WRITE (2) or none (0). The bench acts as the memory.
  task automatic apply_stimulus(input bit b, input logic [3:0] rd, input logic [31:0] rn,
                                input logic [31:0] rm, input int rw, input int ww, input int ab);
    logic [31:0] key, pre, val, nw, ea, ewd, wkey;
    logic [3:0]  ebe;
    int          k;
    exp_t        e;
    k   = int'(rn % 4);
    key = rn >> 2;
    pre = mem_get(key);
    model(b, rn, pre, rm, val, nw);
    ea  = b ? rn : (rn & ~32'h3);
    ebe = b ? (4'b0001 << k) : 4'b1111;
    ewd = b ? {4{rm[7:0]}} : rm;

    start = 1'b1; swap_byte = b; rd_idx = rd; rn_data = rn; rm_data = rm;
    e.is_abort   = (ab != 0);
    e.rd         = rd;
    e.val        = val;
    e.key        = key;
    e.final_word = (ab != 0) ? pre : nw;
    e.cycle      = cyc + ((ab == 1) ? (2 + rw) : (3 + rw + ww));
    sb.push_back(e);
    step();
    start = 1'b0; rn_data = $urandom; rm_data = $urandom; rd_idx = 4'($urandom); swap_byte = 1'($urandom);

    for (int i = 0; i <= rw; i++) begin
      check_bus(1'b0, ea, ebe, ewd);
      if (i < rw) begin
        mem_ready = 1'b0; mem_rdata = $urandom;
      end else begin
        mem_ready = 1'b1; mem_abort = (ab == 1); mem_rdata = mem_get(mem_addr >> 2);
      end
      step();
    end
    mem_ready = 1'b0; mem_abort = 1'b0; mem_rdata = $urandom;
    if (ab == 1) begin
      check_output("rabort_we", mem_we, 0);
      check_output("rabort_busy", busy, 0);
      check_output("rabort_lock", mem_lock, 0);
      return;
    end

    for (int i = 0; i <= ww; i++) begin
      check_bus(1'b1, ea, ebe, ewd);
      if (i < ww) begin
        mem_ready = 1'b0;
      end else begin
        mem_ready = 1'b1;
        if (ab == 2) begin
          mem_abort = 1'b1;
        end else begin
          wkey = mem_addr >> 2;
          void'(mem_get(wkey));
          for (int j = 0; j < 4; j++)
            if (mem_be[j]) mem[wkey][8*j +: 8] = mem_wdata[8*j +: 8];
        end
      end
      step();
    end
    mem_ready = 1'b0; mem_abort = 1'b0;
    if (ab == 2) begin
      check_output("wabort_busy", busy, 0);
      check_output("wabort_reg_we", reg_we, 0);
      check_output("wabort_lock", mem_lock, 0);
      return;
    end

    check_output("wb_lock", mem_lock, 0);
    check_output("wb_re", mem_re, 0);
    check_output("wb_we", mem_we, 0);
    check_output("wb_busy", busy, 1);
    step();
    check_output("post_busy", busy, 0);
    check_output("post_reg_we", reg_we, 0);
  endtask

  // Scoreboard monitor: every done/abort pulse must match the oldest
  // outstanding expectation, including the cycle it arrives in.
  always @(negedge clk) begin
    if (done || abort) begin
      if (sb.size() == 0) begin
        check_output("unexpected_completion", {30'd0, done, abort}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output("kind_abort", abort, e.is_abort);
        check_output("kind_done", done, !e.is_abort);
        check_output("latency", cyc, e.cycle);
        check_output("reg_we", reg_we, !e.is_abort);
        if (!e.is_abort) begin
          check_output("reg_waddr", {28'd0, reg_waddr}, {28'd0, e.rd});
          check_output("reg_wdata", reg_wdata, e.val);
        end
        check_output("mem_word", mem[e.key], e.final_word);
      end
    end
  end

  // Main sequence: reset, directed cases, reset mid-swap, random swaps.
  initial begin
    cyc = 0; n_run = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; swap_byte = 1'b0; rd_idx = 4'd0;
    rn_data = '0; rm_data = '0; mem_rdata = '0; mem_ready = 1'b0; mem_abort = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    mem[32'h1000] = 32'h12345678;
    apply_stimulus(1'b0, 4'd3, 32'h4000, 32'hDEADBEEF, 0, 0, 0);
    check_output("t1_mem", mem[32'h1000], 32'hDEADBEEF);

    mem[32'h1003] = 32'h87654321;
    apply_stimulus(1'b1, 4'd5, 32'h400D, 32'h000000CD, 0, 0, 0);
    check_output("t2_mem", mem[32'h1003], 32'h8765CD21);

    mem[32'h1000] = 32'h11223344;
    apply_stimulus(1'b0, 4'd7, 32'h4002, 32'hA5A5F00F, 0, 0, 0);

    apply_stimulus(1'b0, 4'd1, 32'h4004, 32'h0BADF00D, 2, 1, 0);

    mem[32'h1002] = 32'hCAFEBABE;
    apply_stimulus(1'b0, 4'd2, 32'h4008, 32'h01020304, 1, 0, 1);
    check_output("t5_mem", mem[32'h1002], 32'hCAFEBABE);

    apply_stimulus(1'b1, 4'd9, 32'h4009, 32'h000000EE, 0, 1, 2);
    check_output("t6_mem", mem[32'h1002], 32'hCAFEBABE);

    // Reset while the write is outstanding.
    mem[32'h1004] = 32'h55667788;
    start = 1'b1; swap_byte = 1'b0; rd_idx = 4'd4; rn_data = 32'h4010; rm_data = 32'h99999999;
    step();
    start = 1'b0; mem_ready = 1'b1; mem_rdata = mem[32'h1004];
    step();
    mem_ready = 1'b0;
    check_output("rstw_we", mem_we, 1);
    check_output("rstw_lock", mem_lock, 1);
    rst = 1'b1;
    step();
    check_all_zero("rstw");
    rst = 1'b0;
    step();
    check_output("rstw_mem", mem[32'h1004], 32'h55667788);
    apply_stimulus(1'b0, 4'd4, 32'h4010, 32'h99999999, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      int r;
      int ab;
      r  = int'($urandom_range(0, 9));
      ab = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
      apply_stimulus(1'($urandom), 4'($urandom), 32'h4000 + 32'($urandom_range(0, 15)),
                     $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), ab);
    end

    repeat (3) step();
    check_output("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/arm7tdmi_swap_unit.md
# arm7tdmi_swap_unit

Multi-cycle execution sequencer for ARM SWP/SWPB. It sits directly downstream of `arm7tdmi_decode` and consumes a decoded `INSTR_SINGLE_SWAP` with its operand values. It performs an atomic, locked read-then-write on the data memory port, then writes the original memory value back to Rd through the register-file write port. While busy it holds the pipeline.

## Interface
Parameters:
- `ADDR_W`, 32: memory address width.
- `DATA_W`, 32: data width. Fixed at 32; the lane logic assumes 4 byte lanes.

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  decoded swap is valid, passed its condition, and is issued this cycle.
- `swap_byte`  in  1  1 = SWPB, 0 = SWP (decode `mem_byte`).
- `rd_idx`  in  4  destination register index.
- `rn_data`  in  32  base address (value of Rn).
- `rm_data`  in  32  store data (value of Rm).
- `mem_addr`  out  32  memory address.
- `mem_wdata`  out  32  write data.
- `mem_rdata`  in  32  read data, valid when `mem_ready`=1.
- `mem_re`  out  1  read request.
- `mem_we`  out  1  write request.
- `mem_be`  out  4  byte enables.
- `mem_lock`  out  1  bus lock; held across the read and the write.
- `mem_ready`  in  1  transfer completes in this cycle.
- `mem_abort`  in  1  data abort; qualified by `mem_ready`.
- `reg_we`  out  1  register write strobe.
- `reg_waddr`  out  4  register write index.
- `reg_wdata`  out  32  register write data.
- `busy`  out  1  unit is not in IDLE; stalls decode and fetch.
- `done`  out  1  one-cycle pulse when the swap completes.
- `abort`  out  1  one-cycle pulse when the swap is terminated by a data abort.

## Operation
- FSM states: IDLE, READ, WRITE, WB.
- IDLE
  - When `start`=1: capture `rn_data`, `rm_data`, `swap_byte`, `rd_idx` into registers, then go to READ.
  - `start` is ignored in any state other than IDLE.
- READ
  - Drives `mem_re`=1, `mem_lock`=1.
  - Waits for `mem_ready`.
    - If `mem_abort`=1 at that point: pulse `abort` and go to IDLE. No write occurs and no register write occurs.
    - Otherwise: latch the result into `rdata_q` and go to WRITE.
- WRITE
  - Drives `mem_we`=1, `mem_lock`=1.
  - Waits for `mem_ready`.
    - If `mem_abort`=1: pulse `abort` and go to IDLE, with no register write.
    - Otherwise: go to WB.
- WB
  - `reg_we`=1, `reg_waddr`=captured Rd, `reg_wdata`=`rdata_q`.
  - `done`=1 for this cycle, then go to IDLE.
- Address:
  - SWPB: `mem_addr` = captured address.
  - SWP: `mem_addr` = captured address with bits [1:0] forced to 00.
  - The same address is used for both the read and the write.
- Read data:
  - SWP: `mem_rdata` rotated right by 8×addr[1:0]. This is the ARM7 unaligned-load rotation.
  - SWPB: byte lane addr[1:0], zero-extended to 32 bits.
- Write data and enables:
  - SWP: `mem_wdata` = Rm, `mem_be`=1111.
  - SWPB: `mem_wdata` = Rm[7:0] replicated on all four lanes, `mem_be` = 1 << addr[1:0].
- Rd == Rm or Rd == Rn is legal. Operands are captured at `start`, so writing Rd in WB cannot corrupt the swap.
- `busy` = state != IDLE. Decode must hold the next instruction while `busy`=1.

## Timing
- Reset:
  - state = IDLE.
  - `mem_re`, `mem_we`, `mem_lock`, `reg_we`, `done`, `abort`, `busy` = 0.
  - `mem_be`=0000.
  - `mem_addr`, `mem_wdata`, `reg_waddr`, `reg_wdata` = 0.
- All memory and register outputs are Moore outputs, decoded from state and captured registers. None are combinational from `start`.
- Zero-wait latency, with `start` high in cycle T:
  - T+1: READ.
  - T+2: WRITE.
  - T+3: WB, with `done` and `reg_we`.
  - T+4: IDLE; a new `start` is accepted in T+4.
- Each cycle of `mem_ready`=0 in READ or WRITE adds one cycle. All request outputs hold steady while waiting.
- `mem_lock` is 1 continuously from the first READ cycle through the last WRITE cycle, with no gap between them. It is 0 in WB and IDLE.
- Reset while in any state: at the next edge, state goes to IDLE and all outputs take reset values. `mem_lock` drops immediately, and no register write is issued.
- `done` and `abort` are never asserted in the same cycle.

## Structure
- `arm7tdmi_pkg`:
  - Add `swap_state_t` enum (IDLE, READ, WRITE, WB).
  - Add `BYTE_LANES`=4.
  - Reuse the existing `instr_type_t`/`INSTR_SINGLE_SWAP`.
- Optional sub-module `arm7tdmi_swap_lane`, a purely combinational block containing:
  - rotate and zero-extend on reads;
  - byte replication and `be` generation on writes.
- Everything else lives in a single module.

## Test plan
- SWP, address 0x4000, memory 0x12345678, Rm 0xDEADBEEF, zero-wait:
  - `mem_be`=1111.
  - Memory becomes 0xDEADBEEF.
  - `reg_wdata`=0x12345678 with `reg_we` and `done` at T+3.
  - `busy` is low at T+4.
- SWPB, address 0x400D, memory 0x87654321, Rm 0x000000CD:
  - `mem_be`=0010, `mem_wdata`=0xCDCDCDCD.
  - Memory becomes 0x8765CD21.
  - `reg_wdata`=0x00000043.
- SWP, address 0x4002, memory 0x11223344:
  - `mem_addr`=0x4000.
  - `reg_wdata`=0x33441122 (rotated right by 16).
  - Whole word is written.
- `mem_ready` low for 2 cycles in READ and 1 cycle in WRITE:
  - `mem_lock` stays high throughout.
  - Request outputs stay stable.
  - `done` arrives at T+6.
- `mem_abort` with `mem_ready` in READ:
  - `abort` pulses.
  - No `mem_we` and no `reg_we` occur.
  - Unit returns to IDLE the next cycle.
  - Memory is unchanged.
- `rst`=1 during WRITE:
  - At the next edge all outputs are 0 and `mem_lock`=0.
  - No `reg_we` occurs.
  - A subsequent `start` completes normally.
